// File: rtl/obtc_pkg.sv
// Shared constants, FSM state type and nibble quantizer for the oBTC PE
// result path.
package obtc_pkg;

  localparam int PE_W      = 14;
  localparam int SHIFT     = 10;
  localparam int NROWS_DEF = 64;
  localparam int LANES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    OUT  = 2'd2
  } pqx_state_t;

  // Plain truncation: bits above SHIFT+3 and below SHIFT are dropped.
  function automatic logic [3:0] quant_nibble(input logic [PE_W-1:0] sum);
    return sum[SHIFT+3:SHIFT];
  endfunction

endpackage

// File: rtl/pe_byte_pack.sv
// One output byte: two quantized PE sums packed high/low and XORed with
// the matching digest byte.
module pe_byte_pack
  import obtc_pkg::*;
(
  input  logic [PE_W-1:0] sum_even,
  input  logic [PE_W-1:0] sum_odd,
  input  logic [7:0]      dig_byte,
  output logic [7:0]      res_byte
);

  assign res_byte = dig_byte ^ {quant_nibble(sum_even), quant_nibble(sum_odd)};

endmodule

// File: rtl/pe_quant_xor.sv
// Captures a PE result set plus digest, quantizes and XORs LANES rows per
// cycle into the output register, then holds it on a valid/ready port.
module pe_quant_xor
  import obtc_pkg::*;
#(
  parameter int NROWS = NROWS_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pe_valid,
  output logic                  pe_ready,
  input  logic [NROWS*PE_W-1:0] pe_sum,
  input  logic [NROWS*4-1:0]    digest,
  output logic                  pe_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NROWS*4-1:0]    out_data
);

  localparam int NSTEP = NROWS / LANES;
  localparam int NB    = LANES / 2;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  generate
    if ((NROWS % 2 != 0) || (LANES % 2 != 0) || (LANES < 2) || (NROWS % LANES != 0)) begin : g_bad_param
      $error("pe_quant_xor: NROWS and LANES must be even and LANES must divide NROWS");
    end
  endgenerate

  pqx_state_t             state_r;
  pqx_state_t             state_nx_s;
  logic [CW-1:0]          lane_cnt_r;
  logic [NROWS*PE_W-1:0]  snap_sum_r;
  logic [NROWS*4-1:0]     snap_dig_r;
  logic [NROWS*4-1:0]     out_data_r;
  logic                   pe_clr_r;
  logic                   accept_s;
  int                     lane_base_s;
  logic [7:0]             byte_s [NB];

  assign accept_s    = pe_valid && (state_r == IDLE);
  assign pe_ready    = (state_r == IDLE);
  assign out_valid   = (state_r == OUT);
  assign pe_clr      = pe_clr_r;
  assign out_data    = out_data_r;
  assign lane_base_s = int'(lane_cnt_r) * LANES;

  // Lane mux: the current lane group of rows feeds the byte slices.
  for (genvar k = 0; k < NB; k++) begin : g_pack
    pe_byte_pack u_pack (
      .sum_even (snap_sum_r[(lane_base_s + 2*k)     * PE_W +: PE_W]),
      .sum_odd  (snap_sum_r[(lane_base_s + 2*k + 1) * PE_W +: PE_W]),
      .dig_byte (snap_dig_r[(lane_base_s / 2 + k) * 8 +: 8]),
      .res_byte (byte_s[k])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx_s = PROC;
        else          state_nx_s = IDLE;
      end
      PROC: begin
        if (lane_cnt_r == LAST) state_nx_s = OUT;
        else                    state_nx_s = PROC;
      end
      OUT: begin
        if (out_ready) state_nx_s = IDLE;
        else           state_nx_s = OUT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Snapshot capture, lane counter, output byte writes and clear pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_r <= '0;
      snap_sum_r <= '0;
      snap_dig_r <= '0;
      out_data_r <= '0;
      pe_clr_r   <= 1'b0;
    end else begin
      pe_clr_r <= accept_s;
      if (accept_s) begin
        snap_sum_r <= pe_sum;
        snap_dig_r <= digest;
        lane_cnt_r <= '0;
      end else if (state_r == PROC) begin
        lane_cnt_r <= lane_cnt_r + CW'(1);
        for (int k = 0; k < NB; k++) begin
          out_data_r[(lane_base_s / 2 + k) * 8 +: 8] <= byte_s[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_quant_xor.sv
// Directed and randomized bench for pe_quant_xor against an arithmetic
// model of the quantize/pack/XOR rule.
module tb_pe_quant_xor;

  localparam int NROWS = 64;
  localparam int NBYTE = NROWS / 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               pe_valid;
  logic               pe_ready;
  logic [NROWS*14-1:0] pe_sum;
  logic [NROWS*4-1:0] digest;
  logic               pe_clr;
  logic               out_valid;
  logic               out_ready;
  logic [NROWS*4-1:0] out_data;

  int n_vec = 0;
  int n_mis = 0;
  int sums [NROWS];
  int dig  [NBYTE];

  pe_quant_xor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pe_valid  (pe_valid),
    .pe_ready  (pe_ready),
    .pe_sum    (pe_sum),
    .digest    (digest),
    .pe_clr    (pe_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] model();
    logic [255:0] r;
    int q0, q1;
    r = '0;
    for (int i = 0; i < NBYTE; i++) begin
      q0 = (sums[2*i] >> 10) & 15;
      q1 = (sums[2*i+1] >> 10) & 15;
      r[8*i +: 8] = 8'((dig[i] & 255) ^ (q0 * 16 + q1));
    end
    return r;
  endfunction

  task automatic apply();
    for (int r = 0; r < NROWS; r++) pe_sum[r*14 +: 14] = 14'(sums[r]);
    for (int i = 0; i < NBYTE; i++) digest[8*i +: 8] = 8'(dig[i]);
    pe_valid = 1'b1;
  endtask

  task automatic fill(input int s, input int d);
    for (int r = 0; r < NROWS; r++) sums[r] = s;
    for (int i = 0; i < NBYTE; i++) dig[i] = d;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < NROWS; r++) sums[r] = int'($urandom_range(0, 16383));
    for (int i = 0; i < NBYTE; i++) dig[i] = int'($urandom_range(0, 255));
  endtask

  // Accept edge through the first cycle of out_valid, with latency checks.
  task automatic run_to_out(input string tag, output logic [255:0] exp);
    exp = model();
    chk({tag, "_pe_ready"}, 256'(pe_ready), 256'(1'b1));
    step();
    pe_valid = 1'b0;
    chk({tag, "_clr_hi"}, 256'(pe_clr), 256'(1'b1));
    chk({tag, "_ov_e0"}, 256'(out_valid), 256'(1'b0));
    for (int c = 1; c <= 8; c++) begin
      step();
      chk({tag, "_clr_lo"}, 256'(pe_clr), 256'(1'b0));
      chk({tag, "_ov_lat"}, 256'(out_valid), 256'(c == 8));
    end
    chk({tag, "_data"}, out_data, exp);
  endtask

  task automatic handshake(input bit rnd, input string tag, input logic [255:0] exp);
    bit done;
    bit r;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = r;
      step();
      if (r) begin
        done = 1'b1;
      end else begin
        chk({tag, "_hold_ov"}, 256'(out_valid), 256'(1'b1));
        chk({tag, "_hold_data"}, out_data, exp);
      end
    end
    out_ready = 1'b0;
    chk({tag, "_hs_done"}, 256'(done), 256'(1'b1));
    chk({tag, "_ov_drop"}, 256'(out_valid), 256'(1'b0));
    chk({tag, "_rdy_back"}, 256'(pe_ready), 256'(1'b1));
  endtask

  initial begin
    logic [255:0] exp_a;
    logic [255:0] exp_b;
    logic [255:0] max_pat;

    rst_n     = 1'b0;
    pe_valid  = 1'b0;
    out_ready = 1'b0;
    pe_sum    = '0;
    digest    = '0;
    repeat (3) step();
    chk("rst_pe_ready", 256'(pe_ready), 256'(1'b1));
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_pe_clr", 256'(pe_clr), 256'(1'b0));
    chk("rst_out_data", out_data, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Zero job.
    fill(0, 0);
    apply();
    run_to_out("zero", exp_a);
    chk("zero_const", out_data, 256'(0));
    handshake(1'b0, "zero", exp_a);

    // Maximum sums.
    fill(14400, 0);
    apply();
    run_to_out("max", exp_a);
    max_pat = {32{8'hEE}};
    chk("max_const", out_data, max_pat);
    handshake(1'b0, "max", exp_a);

    // Quantization boundaries.
    fill(0, 0);
    sums[0]  = 1023;
    sums[1]  = 1024;
    sums[62] = 15360;
    sums[63] = 0;
    dig[0]   = 255;
    apply();
    run_to_out("bnd", exp_a);
    chk("bnd_byte0", 256'(out_data[7:0]), 256'(8'hFE));
    chk("bnd_byte31", 256'(out_data[255:248]), 256'(8'hF0));
    handshake(1'b0, "bnd", exp_a);

    // Backpressure with a second job waiting.
    fill_rand();
    apply();
    run_to_out("bp_a", exp_a);
    fill_rand();
    apply();
    for (int t = 0; t < 20; t++) begin
      step();
      chk("bp_ov", 256'(out_valid), 256'(1'b1));
      chk("bp_data", out_data, exp_a);
      chk("bp_pe_ready", 256'(pe_ready), 256'(1'b0));
      chk("bp_no_clr", 256'(pe_clr), 256'(1'b0));
    end
    handshake(1'b0, "bp_a", exp_a);
    run_to_out("bp_b", exp_b);
    handshake(1'b0, "bp_b", exp_b);

    // Reset in the middle of PROC.
    fill_rand();
    apply();
    step();
    pe_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("mrst_pe_ready", 256'(pe_ready), 256'(1'b1));
    chk("mrst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("mrst_pe_clr", 256'(pe_clr), 256'(1'b0));
    chk("mrst_out_data", out_data, 256'(0));
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      step();
      chk("mrst_no_ov", 256'(out_valid), 256'(1'b0));
    end
    fill_rand();
    apply();
    run_to_out("mrst_job", exp_a);
    handshake(1'b0, "mrst_job", exp_a);

    // Random regression.
    for (int j = 0; j < 1000; j++) begin
      fill_rand();
      apply();
      run_to_out("rand", exp_a);
      handshake(1'b1, "rand", exp_a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
